// File: rtl/alu_seq.sv
// alu_seq: operand sequencer for the bit-serial ALU.
// Shifts two WIDTH-bit operands into the ALU LSB-first and rebuilds the serial result as a word.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [2:0]       i_in_op,
   input  logic [WIDTH-1:0] i_in_a,
   input  logic [WIDTH-1:0] i_in_b,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_out_y,
   output logic             o_out_c,
   output logic             o_alu_rst_n,
   output logic [2:0]       o_alu_op,
   output logic             o_alu_a,
   output logic             o_alu_b,
   input  logic             i_alu_y,
   input  logic             i_alu_c
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_CAPT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sh_a;
   logic [WIDTH-1:0] r_sh_b;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_out_y;
   logic             r_out_c;
   logic [2:0]       r_op;
   logic             w_last_bit;

   assign w_last_bit = (r_cnt == CW'(WIDTH - 1));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      // NOTE: default assignment first, so no branch of the case leaves the signal unassigned (no latch).
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_in_valid) begin
               w_next_state = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_last_bit) begin
               w_next_state = S_CAPT;
            end
         end
         S_CAPT: begin
            w_next_state = S_DONE;
         end
         S_DONE: begin
            if (i_out_ready) begin
               w_next_state = S_IDLE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // The ALU is held in reset outside SHIFT/CAPT so its carry/flag starts clean for each operation.
   always_comb begin
      o_in_ready  = 1'b0;
      o_out_valid = 1'b0;
      o_alu_rst_n = 1'b0;
      o_alu_a     = 1'b0;
      o_alu_b     = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_in_ready = 1'b1;
         end
         S_SHIFT: begin
            o_alu_rst_n = 1'b1;
            o_alu_a     = r_sh_a[0];
            o_alu_b     = r_sh_b[0];
         end
         S_CAPT: begin
            o_alu_rst_n = 1'b1;
         end
         S_DONE: begin
            o_out_valid = 1'b1;
         end
         default: begin
            o_in_ready = 1'b0;
         end
      endcase
   end

   // NOTE: the datapath registers are reset as well, so an aborted operation leaves no residue on the ALU pins.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt   <= '0;
         r_sh_a  <= '0;
         r_sh_b  <= '0;
         r_res   <= '0;
         r_out_y <= '0;
         r_out_c <= 1'b0;
         r_op    <= 3'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_in_valid) begin
                  r_sh_a <= i_in_a;
                  r_sh_b <= i_in_b;
                  r_op   <= i_in_op;
                  r_cnt  <= '0;
                  r_res  <= '0;
               end
            end
            S_SHIFT: begin
               r_sh_a <= {1'b0, r_sh_a[WIDTH-1:1]};
               r_sh_b <= {1'b0, r_sh_b[WIDTH-1:1]};
               r_res  <= {i_alu_y, r_res[WIDTH-1:1]};
               r_cnt  <= r_cnt + CW'(1);
            end
            S_CAPT: begin
               // The flag only reflects all WIDTH bits once the last bit has been clocked in.
               r_out_y <= r_res;
               r_out_c <= i_alu_c;
            end
            default: begin
               r_out_y <= r_out_y;
            end
         endcase
      end
   end

   assign o_out_y  = r_out_y;
   assign o_out_c  = r_out_c;
   assign o_alu_op = r_op;

endmodule
